// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Start/busy/done handshake; bcd_out and ovf update only with done.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          state;
  logic [BIN_W-1:0] bin_sr;
  logic [BW-1:0]   scratch;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   shifted;
  logic            carry;
  logic            acc;
  logic [CW-1:0]   count;

  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // Top bit of the adjusted scratch falls off: value exceeded 10^DIGITS-1.
  assign shifted = {adj[BW-2:0], bin_sr[BIN_W-1]};
  assign carry   = adj[BW-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bin_sr  <= '0;
      scratch <= '0;
      acc     <= 1'b0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= bin_in;
            scratch <= '0;
            acc     <= 1'b0;
            count   <= CW'(BIN_W);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bin_sr  <= bin_sr << 1;
          scratch <= shifted;
          acc     <= acc | carry;
          count   <= count - CW'(1);
          if (count == CW'(1)) begin
            bcd_out <= shifted;
            ovf     <= acc | carry;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: 8-bit/3-digit and 10-bit/3-digit
// instances, expectations queued at start and checked on done.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start8 = 1'b0;
  logic [7:0]  bin8 = '0;
  logic        busy8, done8, ovf8;
  logic [11:0] bcd8;
  logic        start10 = 1'b0;
  logic [9:0]  bin10 = '0;
  logic        busy10, done10, ovf10;
  logic [11:0] bcd10;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int busycnt = 0;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q8[$];
  exp_t q10[$];

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .reset(reset), .start(start8), .bin_in(bin8),
    .busy(busy8), .done(done8), .bcd_out(bcd8), .ovf(ovf8)
  );

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut10 (
    .clk(clk), .reset(reset), .start(start10), .bin_in(bin10),
    .busy(busy10), .done(done10), .bcd_out(bcd10), .ovf(ovf10)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int v);
    exp_t e;
    int m;
    m = v % 1000;
    e.bcd = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    e.ovf = (v > 999);
    e.acc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      busycnt = 0;
    end else begin
      if (busy8) busycnt++;
      if (done8) begin
        if (q8.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q8.pop_front();
          chk("bcd8", bcd8, e.bcd);
          chk("ovf8", ovf8, e.ovf);
          chk("latency", cyc - e.acc, 8);
          chk("busy_cycles", busycnt, 8);
          for (int d = 0; d < 3; d++)
            chk("digit_le9", (bcd8[4*d +: 4] > 4'd9), 0);
        end
        busycnt = 0;
      end
      if (done10) begin
        if (q10.size() == 0) begin
          chk("unexpected_done10", 1, 0);
        end else begin
          exp_t e;
          e = q10.pop_front();
          chk("bcd10", bcd10, e.bcd);
          chk("ovf10", ovf10, e.ovf);
          chk("latency10", cyc - e.acc, 10);
        end
      end
    end
  end

  task automatic go8(input int v);
    exp_t e;
    @(posedge clk); #1;
    start8 = 1'b1;
    bin8 = 8'(v);
    e = mk(v);
    e.acc = cyc + 1;
    q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic go10(input int v);
    exp_t e;
    @(posedge clk); #1;
    start10 = 1'b1;
    bin10 = 10'(v);
    e = mk(v);
    e.acc = cyc + 1;
    q10.push_back(e);
    @(posedge clk); #1;
    start10 = 1'b0;
  endtask

  task automatic wait_done8(output int t);
    logic seen;
    seen = 1'b0;
    t = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (done8) begin
        seen = 1'b1;
        t = cyc;
      end
    end
    chk("done8_seen", seen, 1);
  endtask

  task automatic wait_done10();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (done10) seen = 1'b1;
    end
    chk("done10_seen", seen, 1);
  endtask

  initial begin
    int t1, t2;
    exp_t e;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_bcd", bcd8, 0);
    chk("rst_ovf", ovf8, 0);
    chk("rst_bcd10", bcd10, 0);

    go8(0);
    wait_done8(t1);
    go8(255);
    wait_done8(t1);
    repeat (3) @(negedge clk);
    chk("hold_bcd", bcd8, 12'h255);
    chk("hold_done", done8, 0);

    for (int v = 0; v < 256; v++) begin
      go8(v);
      wait_done8(t1);
    end

    go8(99);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start8 = 1'b1;
    bin8 = 8'd200;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b1;
    bin8 = 8'd128;
    wait_done8(t1);
    e = mk(128);
    e.acc = cyc + 1;
    q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(t2);
    chk("period", t2 - t1, 9);
    repeat (12) @(negedge clk);

    go8(173);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    q8.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_bcd", bcd8, 0);
    repeat (12) @(negedge clk);
    go8(7);
    wait_done8(t1);

    go10(999);
    wait_done10();
    go10(1000);
    wait_done10();
    go10(1023);
    wait_done10();
    go10(512);
    wait_done10();

    repeat (15) @(negedge clk);
    chk("queues_empty", q8.size() + q10.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
